// File: rtl/hi_iso14443a_ssp_link_pkg.sv
// rtl/hi_iso14443a_ssp_link_pkg.sv - shared constants and encodings for the ISO14443A SSP link
package hi_iso14443a_ssp_link_pkg;

  // One SSP frame carries one byte, one bit per slot.
  localparam int         SSP_FRAME_BITS           = 8;
  localparam int         SSP_CLK_DIV_LOG2_DEFAULT = 4;
  localparam logic [7:0] SSP_IDLE_BYTE_DEFAULT    = 8'h00;
  localparam int         SSP_TX_FIFO_DEPTH        = 4;

  // Front-end operating modes, shared with the ISO14443A front end.
  typedef enum logic [2:0] {
    MOD_TYPE_SNIFFER       = 3'd0,
    MOD_TYPE_TAGSIM_LISTEN = 3'd1,
    MOD_TYPE_TAGSIM_MOD    = 3'd2,
    MOD_TYPE_READER_LISTEN = 3'd3,
    MOD_TYPE_READER_MOD    = 3'd4
  } mod_type_e;

  // Bit of the frame byte carried in a given slot: MSB goes out first.
  function automatic logic [2:0] msb_first_index(input logic [2:0] slot);
    return 3'(SSP_FRAME_BITS - 1) - slot;
  endfunction

endpackage

// File: rtl/hi_iso14443a_ssp_link_tx_fifo.sv
// rtl/hi_iso14443a_ssp_link_tx_fifo.sv - ssp_tx_fifo, byte buffer between front end and SSP serialiser
module ssp_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hi_iso14443a_ssp_link.sv
// rtl/hi_iso14443a_ssp_link.sv - SSP link stage (build option SSP_TX_FIFO_EN selects a 4-deep TX FIFO)
module hi_iso14443a_ssp_link
  import hi_iso14443a_ssp_link_pkg::*;
#(
  parameter int         CLK_DIV_LOG2 = SSP_CLK_DIV_LOG2_DEFAULT,
  parameter logic [7:0] IDLE_BYTE    = SSP_IDLE_BYTE_DEFAULT
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_idle,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  input  logic       ssp_dout
);

`ifdef SSP_TX_FIFO_EN
  localparam int TX_DEPTH = SSP_TX_FIFO_DEPTH;
`else
  localparam int TX_DEPTH = 1;
`endif
  localparam int TX_CNT_W = $clog2(TX_DEPTH + 1);

  localparam logic [CLK_DIV_LOG2-1:0] DIV_MAX   = '1;
  localparam logic [CLK_DIV_LOG2-1:0] DIV_HALF  = CLK_DIV_LOG2'(2 ** (CLK_DIV_LOG2 - 1));
  localparam logic [2:0]              LAST_SLOT = 3'(SSP_FRAME_BITS - 1);

  logic [CLK_DIV_LOG2-1:0] div_cnt;
  logic [2:0]              bit_cnt;
  logic [7:0]              tx_shift;
  logic [6:0]              rx_shift;

  logic                    fall_tick;
  logic                    rise_tick;
  logic                    load_point;
  logic [7:0]              next_byte;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic [7:0]              fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [TX_CNT_W-1:0]     fifo_count;

  // ssp_clk falls as div_cnt wraps to 0 and rises at the half count.
  assign fall_tick  = (div_cnt == DIV_MAX);
  assign rise_tick  = (div_cnt == DIV_HALF);
  assign load_point = fall_tick && (bit_cnt == LAST_SLOT);
  assign ssp_clk    = div_cnt[CLK_DIV_LOG2-1];

  // The load point sees the registered count, so a byte pushed on that same
  // cycle waits for the next frame and the idle byte goes out instead.
  assign next_byte = (fifo_count != '0) ? fifo_head : IDLE_BYTE;
  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign fifo_pop  = load_point && !fifo_empty;

  ssp_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (ck_1356meg),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Clock divider and bit-slot counter; bit_cnt advances on each ssp_clk fall.
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CLK_DIV_LOG2'(1);
      if (fall_tick) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // TX serialiser: frame marker, byte load at the end of slot 7, MSB-first shift-out.
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      tx_shift  <= IDLE_BYTE;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b0;
      tx_idle   <= 1'b0;
    end else begin
      ssp_frame <= (bit_cnt == 3'd0);
      tx_idle   <= load_point && (fifo_count == '0);
      if (fall_tick) begin
        if (bit_cnt == LAST_SLOT) begin
          tx_shift <= next_byte;
          ssp_din  <= next_byte[msb_first_index(3'd0)];
        end else begin
          ssp_din  <= tx_shift[msb_first_index(bit_cnt + 3'd1)];
        end
      end
    end
  end

  // RX deserialiser: sample on each ssp_clk rise, publish the byte at slot 7.
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rise_tick) begin
        rx_shift <= {rx_shift[5:0], ssp_dout};
        if (bit_cnt == LAST_SLOT) begin
          rx_data  <= {rx_shift, ssp_dout};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hi_iso14443a_ssp_link.sv
// tb/tb_hi_iso14443a_ssp_link.sv - self-checking bench for hi_iso14443a_ssp_link
module tb_hi_iso14443a_ssp_link;

  localparam logic [7:0] IDLE  = 8'h00;
  localparam int         FRAME = 128;
  localparam int         SLOT  = 16;
`ifdef SSP_TX_FIFO_EN
  localparam int         DEPTH = 4;
`else
  localparam int         DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ssp_dout = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_idle;
  logic       ssp_clk;
  logic       ssp_frame;
  logic       ssp_din;

  hi_iso14443a_ssp_link dut (
    .ck_1356meg (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_idle    (tx_idle),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .ssp_dout   (ssp_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = 0;

  // Reference model: pending bytes, byte on the wire this frame, last RX byte.
  logic [7:0] mq[$];
  logic [7:0] cur_byte;
  bit         cur_idle;
  logic [7:0] m_rx_data;
  logic [7:0] rx_bits;
  logic [7:0] rx_src;

  // Stimulus and observation.
  bit         force_rx = 1'b1;
  logic [7:0] force_rx_byte = 8'h00;
  bit         rand_on = 1'b0;
  logic [7:0] offer[$];
  logic [7:0] cap = 8'h00;
  logic [7:0] last_tx_byte = 8'h00;
  logic [7:0] sent_log[$];
  int idle_pulses, rxv_pulses, frame_cycles, din_ones;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%b want=%b", name, t, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%02h want=%02h", name, t, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    mq.delete();
    offer.delete();
    cur_byte  = IDLE;
    cur_idle  = 1'b0;
    m_rx_data = 8'h00;
    rx_bits   = 8'h00;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    tx_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic reset_literals(input string tag);
    chk1({tag, "_ssp_clk"}, ssp_clk, 1'b0);
    chk1({tag, "_ssp_frame"}, ssp_frame, 1'b0);
    chk1({tag, "_ssp_din"}, ssp_din, 1'b0);
    chk8({tag, "_rx_data"}, rx_data, 8'h00);
    chk1({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk1({tag, "_tx_idle"}, tx_idle, 1'b0);
    chk1({tag, "_tx_ready"}, tx_ready, 1'b1);
  endtask

  // One clock cycle: compare, observe, drive, advance model, move to next negedge.
  task automatic step();
    int         p;
    logic [2:0] s;
    bit         accept;
    p = t % FRAME;
    s = 3'(p / SLOT);

    chk1("ssp_clk", ssp_clk, (t % SLOT) >= 8);
    chk1("ssp_frame", ssp_frame, (p >= 1) && (p <= 16));
    chk1("ssp_din", ssp_din, cur_byte[3'd7 - s]);
    chk1("tx_idle", tx_idle, (p == 0) && (t > 0) && cur_idle);
    chk1("rx_valid", rx_valid, p == FRAME - SLOT + 9);
    chk8("rx_data", rx_data, m_rx_data);
    chk1("tx_ready", tx_ready, mq.size() < DEPTH);

    if (tx_idle)   idle_pulses++;
    if (rx_valid)  rxv_pulses++;
    if (ssp_frame) frame_cycles++;
    if (ssp_din)   din_ones++;
    if (p % SLOT == 8) cap[3'd7 - s] = ssp_din;
    if (p == FRAME - 1) begin
      last_tx_byte = cap;
      sent_log.push_back(cap);
    end

    if (p % SLOT == 0) begin
      if (p == 0) rx_src = force_rx ? force_rx_byte : 8'($urandom);
      ssp_dout = rx_src[3'd7 - s];
    end
    if (offer.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = offer.pop_front();
    end else if (rand_on && ($urandom_range(0, 47) == 0)) begin
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end

    accept = tx_valid && (mq.size() < DEPTH);
    if (p == FRAME - 1) begin
      if (mq.size() > 0) begin
        cur_byte = mq.pop_front();
        cur_idle = 1'b0;
      end else begin
        cur_byte = IDLE;
        cur_idle = 1'b1;
      end
    end
    if (accept) mq.push_back(tx_data);
    if (p % SLOT == 8) begin
      rx_bits[3'd7 - s] = ssp_dout;
      if (p == FRAME - SLOT + 8) m_rx_data = rx_bits;
    end

    @(negedge clk);
    t++;
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while ((t % FRAME) != target && n < 300) begin
      step();
      n++;
    end
    if ((t % FRAME) != target) begin
      checks++;
      failures++;
      $display("FAIL run_until target=%0d t=%0d", target, t);
    end
  endtask

  initial begin
    do_reset(3);
    reset_literals("rst");

    // Idle: three frames of IDLE_BYTE with ARM sending zeros.
    idle_pulses = 0; rxv_pulses = 0; frame_cycles = 0; din_ones = 0;
    repeat (3 * FRAME + 1) step();
    chkn("idle_tx_idle_pulses", idle_pulses, 3);
    chkn("idle_rx_valid_pulses", rxv_pulses, 3);
    chkn("idle_frame_cycles", frame_cycles, 48);
    chkn("idle_din_ones", din_ones, 0);
    chk8("idle_rx_data", rx_data, 8'h00);

    // Single byte pushed mid-frame.
    run_until(40);
    offer.push_back(8'hA5);
    run_until(0);
    chk1("a5_no_idle", tx_idle, 1'b0);
    run_until(FRAME - 1);
    step();
    chk8("a5_bits", last_tx_byte, 8'hA5);

    // RX capture of 0x3C.
    force_rx_byte = 8'h3C;
    run_until(FRAME - SLOT + 9);
    chk1("rx3c_valid", rx_valid, 1'b1);
    chk8("rx3c_data", rx_data, 8'h3C);
    force_rx = 1'b0;

`ifdef SSP_TX_FIFO_EN
    // Back-pressure: five consecutive offers, four accepted.
    run_until(10);
    for (int i = 1; i <= 5; i++) offer.push_back(8'(i));
    repeat (5) step();
    chk1("bp_ready_low", tx_ready, 1'b0);
    run_until(FRAME - 1);
    step();
    sent_log.delete();
    repeat (4) begin
      run_until(FRAME - 1);
      step();
    end
    chkn("bp_sent_count", sent_log.size(), 4);
    if (sent_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk8("bp_sent_byte", sent_log[i], 8'(i + 1));
    end
    chk1("bp_ready_high", tx_ready, 1'b1);
`endif

    // Reset at slot 4 with 0x55 on the wire and more bytes queued.
    run_until(50);
    offer.push_back(8'h55);
    run_until(0);
    offer.push_back(8'h11);
    offer.push_back(8'h22);
    run_until(64);
    do_reset(1);
    reset_literals("mid");
    run_until(FRAME - 1);
    step();
    chk8("mid_frame0_byte", last_tx_byte, 8'h00);
    chk1("mid_idle_pulse", tx_idle, 1'b1);
    run_until(FRAME - 1);
    step();
    chk8("mid_frame1_byte", last_tx_byte, 8'h00);

    // Push into an empty buffer exactly at the load point.
    run_until(FRAME - 1);
    offer.push_back(8'h6B);
    step();
    chk1("lp_idle_pulse", tx_idle, 1'b1);
    run_until(FRAME - 1);
    step();
    chk8("lp_idle_frame", last_tx_byte, 8'h00);
    run_until(FRAME - 1);
    step();
    chk8("lp_byte_frame", last_tx_byte, 8'h6B);

    // Randomised traffic, then a reset at a random phase.
    rand_on = 1'b1;
    repeat (20 * FRAME) step();
    repeat ($urandom_range(0, FRAME - 1)) step();
    do_reset(1);
    reset_literals("rnd");
    repeat (6 * FRAME) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
